// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// The decode and writeback stages import the same defaults.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // At least one address bit, even for a degenerate single-entry file.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Read/write bundle between the pipeline stages (master) and the register file (slave).
// Handshake: there is no backpressure. Writes are accepted on any rising edge where ready = 1; reads are purely combinational.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2
);
    localparam int AW = addr_width(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we0;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic                we1;
    logic                ready;
    logic                wr_collision;
    state_e              dbg_state;

    modport master (
        output rd_addr, wa0, wd0, we0, wa1, wd1, we1,
        input  rd_data, ready, wr_collision, dbg_state
    );

    modport slave (
        input  rd_addr, wa0, wd0, we0, wa1, wd1, we1,
        output rd_data, ready, wr_collision, dbg_state
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sweep: walks every register address once, then raises ready.
// State is exported so checkers can follow the sweep directly.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = addr_width(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic          ready,
    output state_e        state
);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ready_q <= ready_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        clr_en   = 1'b0;
        clr_addr = cnt_q;
        if (rst) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = ready_q;
    assign state = state_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports (port 1 wins), NRD
// combinational read ports with write-first bypass, optional hardwired x0.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_width(NREG)
) (
    input  logic       clk,
    input  logic       rst,
    regfile_if.slave   bus
);
    localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

    logic [XLEN-1:0] mem [NREG];
    logic            clr_en;
    logic [AW-1:0]   clr_addr;
    logic            ready;
    logic            wr0_ok, wr1_ok;
    logic            col_q;

    regfile_clear_seq #(.NREG(NREG), .AW(AW)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .ready    (ready),
        .state    (bus.dbg_state)
    );

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr0_ok = ready && bus.we0 && addr_ok(bus.wa0);
    assign wr1_ok = ready && bus.we1 && addr_ok(bus.wa1);

    // Port 1 is written last so it overrides port 0 on a shared address.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr0_ok) mem[bus.wa0] <= bus.wd0;
            if (wr1_ok) mem[bus.wa1] <= bus.wd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) col_q <= 1'b0;
        else     col_q <= wr0_ok && wr1_ok && (bus.wa0 == bus.wa1);
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        assign ra = bus.rd_addr[i*AW +: AW];
        always_comb begin
            val = '0;
            if (ready && addr_ok(ra)) begin
                if (wr1_ok && bus.wa1 == ra)      val = bus.wd1;
                else if (wr0_ok && bus.wa0 == ra) val = bus.wd0;
                else                              val = mem[ra];
            end
        end
        assign bus.rd_data[i*XLEN +: XLEN] = val;
    end

    assign bus.ready        = ready;
    assign bus.wr_collision = col_q;

endmodule
